// File: rtl/zigzag_quant_stream_pkg.sv
// Shared encodings and fixed-point helpers for the zigzag quantiser stream.
// Helpers work on a wide signed carrier so callers pick their own widths.
package zigzag_quant_stream_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam int unsigned CALC_W = 128;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Reciprocal for q=1, i.e. 2^recip_w.
    function automatic calc_t recip_one(input int unsigned recip_w);
        return calc_t'(1) << recip_w;
    endfunction

    function automatic calc_t round_half_away(input calc_t p, input int unsigned shift);
        calc_t mag;
        calc_t r;
        mag = p[CALC_W-1] ? -p : p;
        r   = (mag + (calc_t'(1) << (shift - 1))) >> shift;
        return p[CALC_W-1] ? -r : r;
    endfunction

    function automatic calc_t saturate(input calc_t v, input int unsigned w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) << (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/zigzag_quant_stream_walker.sv
// Zigzag (row, col) walker over an N x N block; start wins over step.
module zigzag_walker
    import zigzag_quant_stream_pkg::*;
#(
    parameter int unsigned N = 8
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic                 step,
    output logic [$clog2(N)-1:0] row,
    output logic [$clog2(N)-1:0] col,
    output logic                 last
);
    localparam int unsigned     RC_W = $clog2(N);
    localparam logic [RC_W-1:0] MAX  = RC_W'(N - 1);

    logic [RC_W-1:0] r_row;
    logic [RC_W-1:0] r_col;
    dir_t            r_dir;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
            r_dir <= DIR_UP;
        end else if (en) begin
            if (start) begin
                r_row <= '0;
                r_col <= '0;
                r_dir <= DIR_UP;
            end else if (step) begin
                if (r_dir == DIR_UP) begin
                    if (r_col == MAX) begin
                        r_row <= r_row + 1'b1;
                        r_dir <= DIR_DOWN;
                    end else if (r_row == '0) begin
                        r_col <= r_col + 1'b1;
                        r_dir <= DIR_DOWN;
                    end else begin
                        r_row <= r_row - 1'b1;
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    if (r_row == MAX) begin
                        r_col <= r_col + 1'b1;
                        r_dir <= DIR_UP;
                    end else if (r_col == '0) begin
                        r_row <= r_row + 1'b1;
                        r_dir <= DIR_UP;
                    end else begin
                        r_row <= r_row + 1'b1;
                        r_col <= r_col - 1'b1;
                    end
                end
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == MAX) && (r_col == MAX);

endmodule

// File: rtl/zigzag_quant_stream.sv
// Ping-pong block buffer, reciprocal quantiser and zigzag readout with
// valid/ready output and end-of-block flag.
module zigzag_quant_stream
    import zigzag_quant_stream_pkg::*;
#(
    parameter  int unsigned N       = 8,
    parameter  int unsigned IN_W    = 32,
    parameter  int unsigned OUT_W   = 16,
    parameter  int unsigned RECIP_W = 16,
    localparam int unsigned IDX_W   = $clog2(N * N)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                bypass,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_last,
    input  logic                out_ready,
    input  logic                qt_we,
    input  logic [IDX_W-1:0]    qt_addr,
    input  logic [RECIP_W:0]    qt_data,
    output logic                idle
);
    localparam int unsigned      NN       = N * N;
    localparam int unsigned      RC_W     = $clog2(N);
    localparam int unsigned      P_W      = IN_W + RECIP_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [RECIP_W:0] Q_ONE    = (RECIP_W + 1)'(recip_one(RECIP_W));

    logic [IN_W-1:0]     r_bank [2][NN];
    logic [RECIP_W:0]    r_table [NN];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [IDX_W-1:0]    r_wr_idx;
    state_t              r_state;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;
    logic                r_out_last;

    logic [RC_W-1:0]     w_row;
    logic [RC_W-1:0]     w_col;
    logic                w_last;
    logic                w_accept;
    logic                w_issue;
    logic                w_start;
    logic                w_step;
    logic                w_idle;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [IN_W-1:0]     w_rd_coef;
    logic [RECIP_W:0]    w_recip;
    logic signed [P_W-1:0] w_prod;
    logic [OUT_W-1:0]    w_beat;

    assign in_ready = en & ~reset & ~r_full[r_wr_bank];
    assign w_accept = in_valid & in_ready;
    assign w_issue  = en & (r_state == ST_RUN) & (~r_out_valid | out_ready);
    // Restart on the final beat when the other bank is waiting: no bubble.
    assign w_start  = en & (((r_state == ST_IDLE) & r_full[r_rd_bank]) |
                            (w_issue & w_last & r_full[~r_rd_bank]));
    assign w_step   = w_issue & ~w_last;
    assign w_idle   = ~|r_full & (r_state == ST_IDLE) & ~r_out_valid;

    // N is a power of two, so {row, col} is row*N + col.
    assign w_rd_idx  = {w_row, w_col};
    assign w_rd_coef = r_bank[r_rd_bank][w_rd_idx];
    assign w_recip   = r_table[w_rd_idx];
    assign w_prod    = $signed(w_rd_coef) * $signed({1'b0, w_recip});
    assign w_beat    = bypass
        ? OUT_W'(saturate(calc_t'($signed(w_rd_coef)), OUT_W))
        : OUT_W'(saturate(round_half_away(calc_t'(w_prod), RECIP_W), OUT_W));

    zigzag_walker #(.N(N)) u_walker (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .start (w_start),
        .step  (w_step),
        .row   (w_row),
        .col   (w_col),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (w_accept) r_bank[r_wr_bank][r_wr_idx] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NN; i++) r_table[i] <= Q_ONE;
        end else if (en && qt_we && w_idle) begin
            r_table[qt_addr] <= qt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (w_accept) begin
            if (r_wr_idx == LAST_IDX) begin
                r_wr_idx  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_idx  <= r_wr_idx + 1'b1;
            end
        end
    end

    // Fill and drain always target different banks, so both full updates apply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full      <= '0;
            r_rd_bank   <= 1'b0;
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (en) begin
            if (w_accept && r_wr_idx == LAST_IDX) r_full[r_wr_bank] <= 1'b1;
            case (r_state)
                ST_IDLE: if (r_full[r_rd_bank]) r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_issue && w_last) begin
                        r_full[r_rd_bank] <= 1'b0;
                        r_rd_bank         <= ~r_rd_bank;
                        r_state           <= r_full[~r_rd_bank] ? ST_RUN : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat;
                r_out_last  <= w_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign idle      = w_idle;

endmodule

// File: tb/tb_zigzag_quant_stream.sv
// Directed bench for zigzag_quant_stream with a diagonal-sort zigzag model
// and a scoreboard of expected output beats.
module tb_zigzag_quant_stream;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        bypass = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        qt_we = 1'b0;
    logic [5:0]  qt_addr = '0;
    logic [16:0] qt_data = '0;
    logic        idle;

    always #5 clk = ~clk;

    zigzag_quant_stream #(.N(8), .IN_W(32), .OUT_W(16), .RECIP_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .bypass(bypass),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .qt_we(qt_we), .qt_addr(qt_addr),
        .qt_data(qt_data), .idle(idle)
    );

    typedef struct {
        longint data;
        bit     last;
    } exp_t;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     zz[NN];
    longint mtab[NN];
    longint blk[NN];
    longint got[NN];
    int     beat_idx = 0;
    int     n_done = 0;
    int     n_beats = 0;
    int     n_last_seen = 0;
    bit     tgl_mode = 1'b0;
    bit     saw_stall = 1'b0;

    // Zigzag order: sort by anti-diagonal; even diagonals run bottom-up.
    function automatic void build_zz();
        int k;
        int r;
        int c;
        k = 0;
        for (int s = 0; s <= 2 * (N - 1); s++) begin
            for (int j = 0; j < N; j++) begin
                r = (s % 2 == 0) ? (N - 1 - j) : j;
                c = s - r;
                if (c >= 0 && c < N) begin
                    zz[k] = r * N + c;
                    k++;
                end
            end
        end
    endfunction

    function automatic longint quant(longint x, longint recip, bit byp);
        longint p;
        longint r;
        if (byp) r = x;
        else begin
            p = x * recip;
            if (p >= 0) r = (p + 32768) / 65536;
            else        r = -((-p + 32768) / 65536);
        end
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_block(input bit byp);
        exp_t e;
        for (int k = 0; k < NN; k++) begin
            e.data = quant(blk[zz[k]], mtab[zz[k]], byp);
            e.last = (k == NN - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_block();
        int guard;
        bit acc;
        for (int i = 0; i < NN; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(blk[i]);
            guard    = 0;
            forever begin
                acc = in_ready;
                if (!acc) saw_stall = 1'b1;
                @(posedge clk); #1;
                if (acc) break;
                guard++;
                if (guard > 4000) begin
                    n_tests++; n_fail++;
                    $display("FAIL in_accept_timeout: coefficient %0d never accepted", i);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_blocks(input int target);
        int guard;
        guard = 0;
        while (n_done < target && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (n_done < target) begin
            n_tests++; n_fail++;
            $display("FAIL block_timeout: done %0d, expected %0d", n_done, target);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!idle && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_reached", longint'(idle), 1);
    endtask

    task automatic qt_write(input int addr, input longint val, input bit effective);
        qt_we   = 1'b1;
        qt_addr = 6'(addr);
        qt_data = 17'(val);
        @(posedge clk); #1;
        qt_we = 1'b0;
        if (effective) mtab[addr] = val;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = tgl_mode ? ~out_ready : 1'b1;
        end
    end

    always @(posedge clk) if (!reset) ;

    // Scoreboard: a beat transfers at the next edge when valid & ready & en.
    always @(negedge clk) begin
        exp_t e;
        longint act;
        if (reset) begin
            beat_idx = 0;
        end else if (en && out_valid && out_ready) begin
            act = longint'($signed(out_data));
            n_beats++;
            if (out_last) n_last_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: data %0d last %0d with empty scoreboard", act, out_last);
            end else begin
                e = exp_q.pop_front();
                if (act != e.data || out_last != e.last) begin
                    n_fail++;
                    $display("FAIL beat%0d: got data %0d last %0d, expected data %0d last %0d",
                             beat_idx, act, out_last, e.data, e.last);
                end
                got[beat_idx] = act;
                if (e.last) begin
                    beat_idx = 0;
                    n_done++;
                end else begin
                    beat_idx++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_beats;
        int base_last;
        int guard;
        logic [15:0] held;

        build_zz();
        for (int i = 0; i < NN; i++) mtab[i] = 65536;

        reset = 1'b1;
        en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_last", longint'(out_last), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", longint'(idle), 1);
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Raster ramp through identity table, with readout latency.
        for (int i = 0; i < NN; i++) blk[i] = i;
        push_block(0);
        send_block();
        check("lat_k", longint'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_k1", longint'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_k2", longint'(out_valid), 1);
        wait_blocks(1);
        check("zz0", got[0], 0);
        check("zz1", got[1], 1);
        check("zz2", got[2], 8);
        check("zz3", got[3], 16);
        check("zz4", got[4], 9);
        check("zz5", got[5], 2);
        check("zz6", got[6], 3);
        check("zz7", got[7], 10);
        check("zz63", got[63], 63);
        check("last_count_1", longint'(n_last_seen), 1);

        // q=16 rounding, half away from zero.
        wait_idle();
        qt_write(0, 4096, 1);
        qt_write(1, 4096, 1);
        qt_write(8, 4096, 1);
        for (int i = 0; i < NN; i++) blk[i] = i;
        blk[0] = 24; blk[1] = -24; blk[8] = 23;
        push_block(0);
        send_block();
        wait_blocks(2);
        check("round_24", got[0], 2);
        check("round_m24", got[1], -2);
        check("round_23", got[2], 1);

        // Saturation, then bypass.
        for (int i = 0; i < NN; i++) blk[i] = i;
        blk[2] = 40000; blk[3] = -40000;
        push_block(0);
        send_block();
        wait_blocks(3);
        check("sat_pos", got[5], 32767);
        check("sat_neg", got[6], -32768);
        bypass = 1'b1;
        blk[0] = 70000; blk[1] = -24;
        push_block(1);
        send_block();
        wait_blocks(4);
        check("byp_sat", got[0], 32767);
        check("byp_raw", got[1], -24);
        wait_idle();
        bypass = 1'b0;

        // Three blocks back-to-back under toggling backpressure.
        tgl_mode   = 1'b1;
        saw_stall  = 1'b0;
        base_beats = n_beats;
        base_last  = n_last_seen;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NN; i++) blk[i] = (i * 37 + b * 101) % 500 - 250;
            push_block(0);
            send_block();
        end
        wait_blocks(7);
        tgl_mode = 1'b0;
        check("bp_beats", longint'(n_beats - base_beats), 192);
        check("bp_lasts", longint'(n_last_seen - base_last), 3);
        check("bp_in_stall", longint'(saw_stall), 1);

        // Table write during readout is dropped; en low freezes outputs.
        wait_idle();
        for (int i = 0; i < NN; i++) blk[i] = i;
        push_block(0);
        send_block();
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("run_out_valid", longint'(out_valid), 1);
        qt_write(0, 8192, 0);
        en   = 1'b0;
        held = out_data;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("en_low_data", longint'(out_data), longint'(held));
            check("en_low_valid", longint'(out_valid), 1);
            check("en_low_in_ready", longint'(in_ready), 0);
        end
        en = 1'b1;
        wait_blocks(8);
        blk[0] = 24;
        push_block(0);
        send_block();
        wait_blocks(9);
        check("qt_run_ignored", got[0], 2);
        wait_idle();
        qt_write(0, 8192, 1);
        push_block(0);
        send_block();
        wait_blocks(10);
        check("qt_idle_applied", got[0], 3);

        // Reset mid-readout.
        for (int i = 0; i < NN; i++) blk[i] = i * 3 - 50;
        push_block(0);
        send_block();
        guard = 0;
        while (beat_idx < 20 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_beat_reached", longint'(beat_idx >= 20), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_out_last", longint'(out_last), 0);
        check("mid_rst_in_ready", longint'(in_ready), 0);
        exp_q.delete();
        for (int i = 0; i < NN; i++) mtab[i] = 65536;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_idle", longint'(idle), 1);
        push_block(0);
        send_block();
        wait_blocks(11);
        check("after_rst_b0", got[0], -50);
        check("after_rst_b1", got[1], -47);
        check("after_rst_b2", got[2], -26);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
